aes_word_stream_adapter: RTL and testbench
==========================================

Name: aes_word_stream_adapter

Overview:
- Upstream/downstream adapter for the AES core (aes_core_fixed / aes_core_optimized port set).
- Assembles four 32-bit words from a valid/ready stream into one 128-bit block and issues a one-cycle start pulse to the core.
- Waits for the core's completion, then serializes the 128-bit result back out as four 32-bit words on a valid/ready stream.
- Includes a watchdog and a cycle-count report for performance comparison.

Parameters:
- TIMEOUT_CYCLES, 256: maximum core cycles allowed after start before an abort.
- CNT_W, 9: width of the latency counter and the last_cycles output. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  128  key; sampled into core_key_in when the first input word is accepted.
- s_valid  in  1  input word valid.
- s_ready  out  1  adapter can accept an input word.
- s_data  in  32  input word.
- s_enc_dec  in  1  mode (1 = encrypt, 0 = decrypt); sampled with the first word of a block.
- core_start  out  1  one-cycle start pulse to the core.
- core_enc_dec  out  1  registered mode to the core.
- core_data_in  out  128  assembled block.
- core_key_in  out  128  registered key.
- core_data_out  in  128  core result.
- core_ready  in  1  core done level.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts an output word.
- m_data  out  32  output word.
- m_last  out  1  high with the 4th output word.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky abort flag; cleared on acceptance of the next first word.
- last_cycles  out  CNT_W  core latency of the last completed block, counted from the cycle after core_start to the cycle core_ready is sampled high.

Behaviour:
- Reset (async assert, sync-release assumed by the system): state = IDLE. All outputs are 0: s_ready, core_start, core_enc_dec, core_data_in, core_key_in, m_valid, m_data, m_last, busy, timeout_err, last_cycles.
- Word order is big-endian, matching FIPS-197 hex strings: word 0 = bits [127:96], word 3 = bits [31:0]. The same order applies on input and output.
- A transfer happens on a clock edge where valid && ready.
- IDLE:
  - s_ready = 1.
  - On a transfer: store word 0, latch s_enc_dec and key_in, clear timeout_err, set the word index to 1, go to LOAD.
- LOAD:
  - s_ready = 1.
  - Each transfer stores the word at the current index.
  - On the transfer of word 3, s_ready drops the next cycle; go to START.
  - Idle cycles (s_valid = 0) are allowed indefinitely; there is no timeout during LOAD.
- START:
  - core_start = 1 for exactly one cycle.
  - core_data_in, core_key_in and core_enc_dec are stable from this cycle until the next block is loaded.
  - Clear the counter; go to WAIT_LOW.
- WAIT_LOW:
  - Counter increments every cycle.
  - If core_ready = 0, go to WAIT_HIGH. This guards against a stale ready left over from the previous operation.
- WAIT_HIGH:
  - Counter increments every cycle.
  - When core_ready = 1: capture core_data_out into the output register, last_cycles <= counter, go to DRAIN.
- Timeout:
  - In WAIT_LOW or WAIT_HIGH, if the counter reaches TIMEOUT_CYCLES: set timeout_err = 1, go to IDLE, emit no output, leave last_cycles unchanged.
  - If core_ready and the timeout occur in the same cycle, the completion wins.
- DRAIN:
  - m_valid = 1; m_data = output word at the current index; m_last = 1 when the index is 3.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - The index advances on each transfer. After the transfer of word 3: m_valid = 0 next cycle, go to IDLE.
- s_ready = 0 in START, WAIT_LOW, WAIT_HIGH and DRAIN. There is no overlap between input and output; throughput is one block in flight.
- Asynchronous reset mid-operation: everything returns to the reset values immediately and any partial block is discarded.
- The counter saturates at 2^CNT_W − 1 and never wraps.

Test Plan:
- Encrypt the FIPS-197 C.1 vector (key 000102030405060708090a0b0c0d0e0f, words 00112233 44556677 8899aabb ccddeeff, enc = 1) against aes_core_fixed:
  - core_start is a single pulse.
  - Output words are 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, with m_last on the 4th word.
  - last_cycles = 129.
- Same vector against aes_core_optimized -> identical output, last_cycles = 32.
- Decrypt ciphertext 3925841d02dc09fbdc118597196a0b32 with key 2b7e151628aed2a6abf7158809cf4f3c:
  - Output is 3243f6a8 885a308d 313198a2 e0370734.
  - last_cycles = 175 (original core) / 44 (optimized core).
- Backpressure:
  - Input: gaps of 0–3 cycles on s_valid.
  - Output: hold m_ready = 0 for 5 cycles on each output word.
  - Required: no word is lost or duplicated, and m_data stays stable while stalled.
- Stub core that never asserts ready, TIMEOUT_CYCLES = 256:
  - timeout_err = 1 and state returns to IDLE after 256 wait cycles, with no m_valid.
  - The next block's first word clears timeout_err.
- Stub core holding core_ready = 1 for 3 cycles after start, then low, then high:
  - The adapter ignores the stale ready and captures only after the low→high sequence.
- Assert rst_n = 0 after 2 input words:
  - All outputs are 0 at once.
  - A fresh 4-word block afterwards encrypts correctly.

Source files
------------

// File: rtl/aes_word_stream_if.sv
// Word stream bundle between the AES adapter and its environment: one
// 32-bit input stream (s_*) into the adapter and one 32-bit output stream
// (m_*) out of it.
//
// Handshake: a word moves on a rising clock edge where valid && ready are
// both high. The sender keeps valid high and its payload (data, enc_dec,
// last) unchanged until that transfer, and never withdraws valid.
interface aes_word_stream_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_enc_dec;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  // Adapter view: sinks the s stream, sources the m stream.
  modport slave (
    input  s_valid, s_data, s_enc_dec, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // Environment view: sources the s stream, sinks the m stream.
  modport master (
    output s_valid, s_data, s_enc_dec, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/aes_word_stream_adapter.sv
// Packs four big-endian 32-bit words into a 128-bit AES block, starts the
// core, waits for completion under a watchdog, then unpacks the result into
// four words. The core latency of every completed block is reported on
// last_cycles. One block is in flight at a time.
module aes_word_stream_adapter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         key_in,
  aes_word_stream_if.slave     bus,
  output logic                 core_start,
  output logic                 core_enc_dec,
  output logic [127:0]         core_data_in,
  output logic [127:0]         core_key_in,
  input  logic [127:0]         core_data_out,
  input  logic                 core_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     last_cycles,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t             state;
  logic [1:0]         in_idx;
  logic [1:0]         out_idx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [127:0]       result;
  logic               s_fire;
  logic               m_fire;

  // Word 0 is the most significant word, as in FIPS-197 hex strings.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    word_of = blk[127:96];
      2'd1:    word_of = blk[95:64];
      2'd2:    word_of = blk[63:32];
      default: word_of = blk[31:0];
    endcase
  endfunction

  // cnt_inc is the wait-cycle number of the current cycle (1 = first cycle
  // after the start pulse); it saturates instead of wrapping.
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign s_fire    = bus.s_valid && bus.s_ready;
  assign m_fire    = bus.m_valid && bus.m_ready;
  assign dbg_state = state;

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_idx       <= 2'd0;
      out_idx      <= 2'd0;
      cnt          <= '0;
      result       <= '0;
      bus.s_ready  <= 1'b0;
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.m_last   <= 1'b0;
      core_start   <= 1'b0;
      core_enc_dec <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      last_cycles  <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          bus.s_ready <= 1'b1;
          if (s_fire) begin
            core_data_in[127:96] <= bus.s_data;
            core_enc_dec         <= bus.s_enc_dec;
            core_key_in          <= key_in;
            timeout_err          <= 1'b0;
            in_idx               <= 2'd1;
            busy                 <= 1'b1;
            state                <= LOAD;
          end
        end
        LOAD: begin
          if (s_fire) begin
            case (in_idx)
              2'd1:    core_data_in[95:64] <= bus.s_data;
              2'd2:    core_data_in[63:32] <= bus.s_data;
              default: core_data_in[31:0]  <= bus.s_data;
            endcase
            if (in_idx == 2'd3) begin
              bus.s_ready <= 1'b0;
              core_start  <= 1'b1;
              state       <= START;
            end else begin
              in_idx <= in_idx + 2'd1;
            end
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // A ready level left high by the previous operation is ignored
          // until the core has visibly dropped it.
          cnt <= cnt_inc;
          if (cnt_inc >= TIMEOUT_VAL) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            bus.s_ready <= 1'b1;
            state       <= IDLE;
          end else if (!core_ready) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          cnt <= cnt_inc;
          if (core_ready) begin
            result      <= core_data_out;
            last_cycles <= cnt_inc;
            out_idx     <= 2'd0;
            bus.m_valid <= 1'b1;
            bus.m_data  <= core_data_out[127:96];
            bus.m_last  <= 1'b0;
            state       <= DRAIN;
          end else if (cnt_inc >= TIMEOUT_VAL) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            bus.s_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          if (m_fire) begin
            if (out_idx == 2'd3) begin
              bus.m_valid <= 1'b0;
              bus.m_last  <= 1'b0;
              busy        <= 1'b0;
              bus.s_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              out_idx    <= out_idx + 2'd1;
              bus.m_data <= word_of(result, out_idx + 2'd1);
              bus.m_last <= (out_idx == 2'd2);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_stream_adapter.sv
// Directed bench for aes_word_stream_adapter. A behavioural stub core returns
// a table-supplied result after a table-supplied latency, optionally with a
// stale ready level at the start of the wait.
module tb_aes_word_stream_adapter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] key_in;
  logic         core_start;
  logic         core_enc_dec;
  logic [127:0] core_data_in;
  logic [127:0] core_key_in;
  logic [127:0] core_data_out;
  logic         core_ready;
  logic         busy;
  logic         timeout_err;
  logic [8:0]   last_cycles;
  logic [2:0]   dbg_state;

  aes_word_stream_if bus ();

  aes_word_stream_adapter #(.TIMEOUT_CYCLES(256), .CNT_W(9)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .bus           (bus),
    .core_start    (core_start),
    .core_enc_dec  (core_enc_dec),
    .core_data_in  (core_data_in),
    .core_key_in   (core_key_in),
    .core_data_out (core_data_out),
    .core_ready    (core_ready),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .last_cycles   (last_cycles),
    .dbg_state     (dbg_state)
  );

  // ---------------- stub core ----------------
  // Wait cycle k (k = 1 is the cycle after the start pulse) sees stub_cyc = k-1.
  int           stub_lat   = 1000;
  int           stub_stale = 0;
  logic [127:0] stub_res   = '0;
  logic         stub_run   = 1'b0;
  logic [15:0]  stub_cyc   = '0;

  always @(posedge clk) begin
    if (core_start) begin
      stub_run <= 1'b1;
      stub_cyc <= '0;
    end else if (stub_run && stub_cyc != 16'hffff) begin
      stub_cyc <= stub_cyc + 16'd1;
    end
  end

  assign core_ready = stub_run && ((int'(stub_cyc) + 1 <= stub_stale) ||
                                   (int'(stub_cyc) + 1 >= stub_lat));
  assign core_data_out = core_ready ? stub_res : ~stub_res;

  // ---------------- observation ----------------
  int           starts_seen = 0;
  int           mvalid_seen = 0;
  logic [127:0] cap_data    = '0;
  logic [127:0] cap_key     = '0;
  logic         cap_enc     = 1'b0;

  always @(negedge clk) begin
    if (core_start) begin
      starts_seen++;
      cap_data = core_data_in;
      cap_key  = core_key_in;
      cap_enc  = core_enc_dec;
    end
    if (bus.m_valid) mvalid_seen++;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] word_at(input logic [127:0] b, input int i);
    return 32'(b >> (96 - 32 * i));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic         enc;
    int           lat;
    int           stale;
    logic [127:0] res;
    bit           gaps;
    int           stall;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic enc, input int gap);
    logic rdy;
    int   n;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid   = 1'b1;
    bus.s_data    = d;
    bus.s_enc_dec = enc;
    n = 0;
    do begin
      rdy = bus.s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) bound_fail("s_ready wait");
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_enc_dec = ~enc;
  endtask

  task automatic drain(input int stall);
    logic [31:0] hd, d, e;
    logic        hl, l;
    int          n;
    for (int w = 0; w < 4; w++) begin
      bus.m_ready = 1'b0;
      n = 0;
      while (!bus.m_valid && n < 600) begin @(posedge clk); #1; n++; end
      if (!bus.m_valid) begin
        bound_fail("m_valid wait");
        return;
      end
      hd = bus.m_data;
      hl = bus.m_last;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("m held while stalled", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, hl, hd});
      end
      d = bus.m_data;
      l = bus.m_last;
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      e = exp_q.pop_front();
      check("m_data", d, e);
      check("m_last", l, (w == 3));
    end
    check("m_valid after word 3", bus.m_valid, 1'b0);
  endtask

  task automatic run_block(input int v);
    int base;
    key_in     = vecs[v].key;
    stub_lat   = vecs[v].lat;
    stub_stale = vecs[v].stale;
    stub_res   = vecs[v].res;
    for (int w = 0; w < 4; w++) exp_q.push_back(word_at(vecs[v].res, w));
    base = starts_seen;
    for (int w = 0; w < 4; w++) begin
      send_word(word_at(vecs[v].blk, w), (w == 0) ? vecs[v].enc : ~vecs[v].enc,
                vecs[v].gaps ? (3 - w) : 0);
      if (w == 0) begin
        check("timeout_err cleared by first word", timeout_err, 1'b0);
        key_in = ~vecs[v].key;
      end
    end
    check("s_ready drops after word 3", bus.s_ready, 1'b0);
    drain(vecs[v].stall);
    check("single start pulse", starts_seen - base, 1);
    check("core_data_in", cap_data, vecs[v].blk);
    check("core_key_in", cap_key, vecs[v].key);
    check("core_enc_dec", cap_enc, vecs[v].enc);
    check("core_data_in stable", core_data_in, vecs[v].blk);
    check("last_cycles", last_cycles, vecs[v].lat);
    check("idle after block", {busy, dbg_state}, 4'd0);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int n;
    int mv;

    vecs[0] = '{K1, P1, 1'b1, 129, 0, C1, 1'b0, 0};  // original core latency
    vecs[1] = '{K1, P1, 1'b1,  32, 0, C1, 1'b0, 0};  // optimized core latency
    vecs[2] = '{K2, C2, 1'b0, 175, 0, P2, 1'b0, 0};
    vecs[3] = '{K2, C2, 1'b0,  44, 0, P2, 1'b0, 0};
    vecs[4] = '{K1, P1, 1'b1, 129, 0, C1, 1'b1, 5};  // input gaps + output stalls
    vecs[5] = '{K2, C2, 1'b0,  10, 3, P2, 1'b0, 1};  // stale ready for 3 cycles
    vecs[6] = '{K1, P1, 1'b1,   2, 0, C1, 1'b1, 0};  // shortest legal latency
    vecs[7] = '{K2, C2, 1'b0, 255, 0, P2, 1'b0, 0};  // one below the watchdog
    vecs[8] = '{K1, P1, 1'b1, 256, 0, C1, 1'b0, 2};  // completion ties the watchdog

    rst_n         = 1'b0;
    key_in        = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_enc_dec = 1'b0;
    bus.m_ready   = 1'b0;
    #23;
    check("reset flags", {bus.s_ready, core_start, core_enc_dec, bus.m_valid, bus.m_last,
                          busy, timeout_err}, '0);
    check("reset buses", {core_data_in, core_key_in}, '0);
    check("reset m_data/last_cycles/state", {bus.m_data, last_cycles, dbg_state}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) run_block(v);

    // Watchdog: the core never answers.
    key_in     = K1;
    stub_lat   = 100000;
    stub_stale = 0;
    mv         = mvalid_seen;
    for (int w = 0; w < 4; w++) send_word(word_at(P1, w), 1'b1, 0);
    n = 0;
    while (busy && n < 400) begin @(posedge clk); #1; n++; end
    if (busy) bound_fail("watchdog abort");
    check("cycles from start to abort", n, 257);
    check("timeout_err set", timeout_err, 1'b1);
    check("no output on abort", mvalid_seen - mv, 0);
    check("last_cycles kept on abort", last_cycles, 256);
    check("idle and ready after abort", {dbg_state, bus.s_ready}, 4'b0001);
    run_block(1);

    // Reset in the middle of loading a block.
    key_in   = K2;
    stub_lat = 32;
    send_word(word_at(C2, 0), 1'b0, 0);
    send_word(word_at(C2, 1), 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset flags", {bus.s_ready, core_start, core_enc_dec, bus.m_valid, bus.m_last,
                              busy, timeout_err}, '0);
    check("mid reset core_data_in", core_data_in, '0);
    check("mid reset core_key_in", core_key_in, '0);
    check("mid reset m_data/last_cycles/state", {bus.m_data, last_cycles, dbg_state}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
